// File: rtl/bow_charge_ctrl.sv
// rtl/bow_charge_ctrl.sv - bow draw/charge sequencer and arrow release; optional BOW_OVERCHARGE_EN
module bow_charge_ctrl #(
  parameter int FRAMES_PER_STAGE = 20,
  parameter int COOLDOWN_FRAMES  = 30,
  parameter int HOLD_LIMIT       = 120
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       game_active,
  input  logic       fire_btn,
  output logic [1:0] bow_frame,
  output logic       arrow_fire,
  output logic [1:0] arrow_power,
  output logic       busy
);

  localparam int MAX_FC = (FRAMES_PER_STAGE > COOLDOWN_FRAMES) ? FRAMES_PER_STAGE : COOLDOWN_FRAMES;
  localparam int MAX_ALL = (MAX_FC > HOLD_LIMIT) ? MAX_FC : HOLD_LIMIT;
  localparam int CW = $clog2(MAX_ALL + 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(FRAMES_PER_STAGE - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_FRAMES - 1);
`ifdef BOW_OVERCHARGE_EN
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_LIMIT - 1);
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHARGE = 2'd1;
  localparam logic [1:0] S_COOL   = 2'd2;

  logic          btn_m, btn_s, btn_s_d;
  logic          press, rel;
  logic [1:0]    state;
  logic [1:0]    stage;
  logic [CW-1:0] fcnt;
  logic [1:0]    bow_reg;
`ifdef BOW_OVERCHARGE_EN
  logic [CW-1:0] hcnt;
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      btn_s_d <= 1'b0;
    end else begin
      btn_m   <= fire_btn;
      btn_s   <= btn_m;
      btn_s_d <= btn_s;
    end
  end

  assign press = btn_s & ~btn_s_d;
  assign rel   = ~btn_s & btn_s_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      stage       <= 2'd0;
      fcnt        <= '0;
      bow_reg     <= 2'd0;
      arrow_fire  <= 1'b0;
      arrow_power <= 2'd0;
`ifdef BOW_OVERCHARGE_EN
      hcnt        <= '0;
`endif
    end else begin
      arrow_fire  <= 1'b0;
      arrow_power <= 2'd0;
      // Sprite select latches pre-transition state so the frame shown is tear-free
      if (frame_start)
        bow_reg <= (state == S_CHARGE) ? stage : 2'd0;
      if (!game_active) begin
        state   <= S_IDLE;
        stage   <= 2'd0;
        fcnt    <= '0;
        bow_reg <= 2'd0;
`ifdef BOW_OVERCHARGE_EN
        hcnt    <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (press) begin
              state <= S_CHARGE;
              stage <= 2'd0;
              fcnt  <= '0;
`ifdef BOW_OVERCHARGE_EN
              hcnt  <= '0;
`endif
            end
          end
          S_CHARGE: begin
            if (rel) begin
              if (stage == 2'd0) begin
                state <= S_IDLE;
              end else begin
                state       <= S_COOL;
                fcnt        <= '0;
                stage       <= 2'd0;
                arrow_fire  <= 1'b1;
                arrow_power <= stage;
              end
            end else if (frame_start) begin
              if (stage != 2'd3) begin
                if (fcnt == STAGE_LAST) begin
                  stage <= stage + 2'd1;
                  fcnt  <= '0;
                end else begin
                  fcnt <= fcnt + CW'(1);
                end
              end
`ifdef BOW_OVERCHARGE_EN
              else if (hcnt == HOLD_LAST) begin
                state       <= S_COOL;
                fcnt        <= '0;
                stage       <= 2'd0;
                arrow_fire  <= 1'b1;
                arrow_power <= 2'd3;
              end else begin
                hcnt <= hcnt + CW'(1);
              end
`endif
            end
          end
          S_COOL: begin
            if (frame_start) begin
              if (fcnt == COOL_LAST) begin
                state <= S_IDLE;
                fcnt  <= '0;
              end else begin
                fcnt <= fcnt + CW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bow_frame = game_active ? bow_reg : 2'd0;
  assign busy      = (state != S_IDLE);

endmodule
